pwm_servo_multi: RTL and testbench

//  N-channel servo PWM generator: one shared period counter, per-channel duty compare.

---
 rtl/pwm_servo_pkg.sv | 16 +
 rtl/pwm_servo_multi_if.sv | 22 ++
 rtl/pwm_servo_chan.sv | 58 +++++
 rtl/pwm_servo_multi.sv | 68 ++++++
 tb/tb_pwm_servo_multi.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_servo_pkg.sv
// rtl/pwm_servo_pkg.sv - shared constants, types and helpers for the multi-channel servo PWM
package pwm_servo_pkg;

    localparam int N_CH_DEF      = 4;
    localparam int W_DEF         = 32;
    localparam int RAMP_STEP_DEF = 16;

    // Channel-select width; a single channel still needs a 1-bit select port.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [ch_width(N_CH_DEF)-1:0] ch_idx_t;
    typedef logic [W_DEF-1:0]              count_t;

endpackage

// File: rtl/pwm_servo_multi_if.sv
// rtl/pwm_servo_multi_if.sv - period/duty write port of the multi-channel servo PWM
interface pwm_servo_multi_if #(
    parameter int N_CH = pwm_servo_pkg::N_CH_DEF,
    parameter int W    = pwm_servo_pkg::W_DEF
);
    localparam int CH_W = pwm_servo_pkg::ch_width(N_CH);

    logic            period_wr;
    logic [W-1:0]    period_in;
    logic            duty_wr;
    logic [CH_W-1:0] duty_ch;
    logic [W-1:0]    duty_in;

    modport master (
        output period_wr, period_in, duty_wr, duty_ch, duty_in
    );

    modport slave (
        input period_wr, period_in, duty_wr, duty_ch, duty_in
    );

endinterface

// File: rtl/pwm_servo_chan.sv
// rtl/pwm_servo_chan.sv - one PWM channel: duty shadow/active, optional ramp (SERVO_RAMP_EN), compare
module pwm_servo_chan #(
    parameter int W         = 32,
    parameter int RAMP_STEP = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         load,
    input  logic         wr,
    input  logic [W-1:0] duty_in,
    input  logic [W-1:0] cnt,
    input  logic         period_nz,
    output logic         pwm
);

`ifdef SERVO_RAMP_EN
    localparam bit RAMP = 1'b1;
`else
    localparam bit RAMP = 1'b0;
`endif

    localparam logic [W-1:0] STEP = W'(RAMP_STEP);

    logic [W-1:0] duty_sh;
    logic [W-1:0] duty_act;
    logic [W-1:0] duty_nxt;
    logic [W-1:0] duty_ramp;
    logic [W-1:0] duty_load;

    // A write in the load cycle bypasses the shadow so it lands at this boundary.
    assign duty_nxt = wr ? duty_in : duty_sh;

    always_comb begin
        duty_ramp = duty_nxt;
        if (duty_nxt > duty_act) begin
            if ((duty_nxt - duty_act) > STEP) duty_ramp = duty_act + STEP;
        end else begin
            if ((duty_act - duty_nxt) > STEP) duty_ramp = duty_act - STEP;
        end
    end

    // While stopped the active duty tracks the shadow directly so a restart is exact.
    assign duty_load = (RAMP && enable) ? duty_ramp : duty_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            duty_sh  <= '0;
            duty_act <= '0;
            pwm      <= 1'b0;
        end else begin
            duty_sh <= duty_nxt;
            if (load) duty_act <= duty_load;
            pwm <= enable && period_nz && (cnt < duty_act);
        end
    end

endmodule

// File: rtl/pwm_servo_multi.sv
// rtl/pwm_servo_multi.sv - N-channel servo PWM with shared period counter; SERVO_RAMP_EN enables duty ramping
module pwm_servo_multi
    import pwm_servo_pkg::*;
#(
    parameter int N_CH      = N_CH_DEF,
    parameter int W         = W_DEF,
    parameter int RAMP_STEP = RAMP_STEP_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    pwm_servo_multi_if.slave  bus,
    output logic [N_CH-1:0]   pwm,
    output logic              frame_tick
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt;
    logic [W-1:0] period_sh;
    logic [W-1:0] period_act;
    logic [W-1:0] period_nxt;
    logic         boundary;
    logic         load;
    logic         period_nz;

    assign period_nxt = bus.period_wr ? bus.period_in : period_sh;
    assign period_nz  = (period_act != '0);
    assign boundary   = enable && (!period_nz || (cnt == period_act - ONE));
    // Stopped: actives follow the shadows every cycle.
    assign load       = boundary || !enable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            period_sh  <= '0;
            period_act <= '0;
            frame_tick <= 1'b0;
        end else begin
            period_sh  <= period_nxt;
            if (load) period_act <= period_nxt;
            if (!enable || boundary) cnt <= '0;
            else                     cnt <= cnt + ONE;
            frame_tick <= boundary;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic wr_sel;
        assign wr_sel = bus.duty_wr && (int'(bus.duty_ch) == i);

        pwm_servo_chan #(
            .W         (W),
            .RAMP_STEP (RAMP_STEP)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .enable    (enable),
            .load      (load),
            .wr        (wr_sel),
            .duty_in   (bus.duty_in),
            .cnt       (cnt),
            .period_nz (period_nz),
            .pwm       (pwm[i])
        );
    end

endmodule

// File: tb/tb_pwm_servo_multi.sv
// tb/tb_pwm_servo_multi.sv - randomized scoreboard bench for pwm_servo_multi against a frame-level model
module tb_pwm_servo_multi;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int RS = 16;
`ifdef SERVO_RAMP_EN
    localparam bit RAMP = 1'b1;
`else
    localparam bit RAMP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [N-1:0] pwm;
    logic         frame_tick;

    pwm_servo_multi_if #(.N_CH(N), .W(W)) bus ();

    pwm_servo_multi #(.N_CH(N), .W(W), .RAMP_STEP(RS)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .bus        (bus),
        .pwm        (pwm),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Each entry is {frame_tick, pwm} expected just after one rising edge.
    logic [N:0] exp_q[$];

    int m_per_sh;
    int m_sh[N];
    int m_act[N];
    bit was_dis;

    task automatic chk(input string name, input int got, input int exp);
        compared++;
        if (got != exp) begin
            mismatched++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    initial begin : monitor
        logic [N:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                compared++;
                if ({frame_tick, pwm} !== e) begin
                    mismatched++;
                    $display("FAIL frame_out got tick/pwm=%b expected=%b at %0t",
                             {frame_tick, pwm}, e, $time);
                end
            end
        end
    end

    function automatic int approach(input int a, input int t);
        if (t > a) return (t - a > RS) ? a + RS : t;
        else       return (a - t > RS) ? a - RS : t;
    endfunction

    task automatic clear_wr();
        bus.period_wr = 1'b0;
        bus.duty_wr   = 1'b0;
    endtask

    task automatic do_write(input bit is_per, input int ch, input int val);
        if (is_per) begin
            bus.period_wr = 1'b1;
            bus.period_in = W'(val);
            m_per_sh      = val;
        end else begin
            bus.duty_wr = 1'b1;
            bus.duty_ch = 2'(ch);
            bus.duty_in = W'(val);
            m_sh[ch]    = val;
        end
    endtask

    task automatic rand_write();
        bit is_per;
        int val;
        is_per = ($urandom_range(0, 3) == 0);
        if (is_per) val = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 40));
        else        val = $urandom_range(0, 50);
        do_write(is_per, $urandom_range(0, N - 1), val);
    endtask

    task automatic dis_write(input bit is_per, input int ch, input int val);
        @(negedge clk);
        enable = 1'b0;
        clear_wr();
        do_write(is_per, ch, val);
        exp_q.push_back('0);
        was_dis = 1'b1;
    endtask

    task automatic run_disabled(input int n, input bit rnd);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            enable = 1'b0;
            clear_wr();
            if (rnd && $urandom_range(0, 1) == 0) rand_write();
            exp_q.push_back('0);
            was_dis = 1'b1;
        end
    endtask

    // A frame lasts max(period,1) cycles; a write in any of its cycles shapes the next frame.
    task automatic run_frames(input int nf, input bit rnd, input int dj, input bit dper,
                              input int dch, input int dval, input int stop_at);
        int p;
        int l;
        logic [N:0] e;
        for (int f = 0; f < nf; f++) begin
            p = m_per_sh;
            for (int i = 0; i < N; i++)
                m_act[i] = (was_dis || !RAMP) ? m_sh[i] : approach(m_act[i], m_sh[i]);
            was_dis = 1'b0;
            l = (p == 0) ? 1 : p;
            for (int j = 0; j < l; j++) begin
                @(negedge clk);
                enable = 1'b1;
                clear_wr();
                if (f == 0 && j == dj) do_write(dper, dch, dval);
                else if (rnd && $urandom_range(0, 7) == 0) rand_write();
                e[N] = (j == l - 1);
                for (int i = 0; i < N; i++) e[i] = (p != 0) && (j < m_act[i]);
                exp_q.push_back(e);
                if (f == 0 && j == stop_at) return;
            end
        end
    endtask

    task automatic model_reset();
        m_per_sh = 0;
        for (int i = 0; i < N; i++) begin
            m_sh[i]  = 0;
            m_act[i] = 0;
        end
        was_dis = 1'b1;
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        clear_wr();
        bus.period_in = '0;
        bus.duty_ch   = '0;
        bus.duty_in   = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("reset_pwm", int'(pwm), 0);
        chk("reset_tick", int'(frame_tick), 0);
        reset = 1'b0;

        // Period 20, duties {5,10,0,25}.
        dis_write(1, 0, 20);
        dis_write(0, 0, 5);
        dis_write(0, 1, 10);
        dis_write(0, 2, 0);
        dis_write(0, 3, 25);
        run_disabled(1, 0);
        run_frames(3, 0, -1, 0, 0, 0, -1);
        // Mid-period duty write, then a write in the boundary cycle.
        run_frames(2, 0, 8, 0, 0, 15, -1);
        run_frames(2, 0, 19, 0, 1, 3, -1);
        // Period 0 frames, then restart with period 10 written in a boundary cycle.
        run_frames(4, 0, 5, 1, 0, 0, -1);
        run_frames(4, 0, 0, 1, 0, 10, -1);
        // Disable mid-frame with writes while stopped.
        run_frames(1, 0, -1, 0, 0, 0, 4);
        run_disabled(3, 1);

        // Async reset at cnt=7 with ch3 high.
        dis_write(1, 0, 20);
        dis_write(0, 3, 25);
        run_frames(1, 0, -1, 0, 0, 0, 7);
        @(posedge clk);
        #2;
        chk("pre_reset_ch3", int'(pwm[3]), 1);
        reset  = 1'b1;
        enable = 1'b0;
        clear_wr();
        #1;
        chk("async_reset_pwm", int'(pwm), 0);
        chk("async_reset_tick", int'(frame_tick), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        run_disabled(2, 0);
        run_frames(3, 0, -1, 0, 0, 0, -1);

        // Duty 0 -> 50 on ch1 (ramps when SERVO_RAMP_EN is defined).
        run_frames(2, 0, 0, 1, 0, 20, -1);
        run_frames(6, 0, 3, 0, 1, 50, -1);

        // Randomized writes with random stop/restart.
        for (int r = 0; r < 6; r++) begin
            run_frames(4, 1, -1, 0, 0, 0, $urandom_range(0, 30));
            run_disabled($urandom_range(1, 3), 1);
        end
        run_frames(6, 1, -1, 0, 0, 0, -1);

        for (int k = 0; k < 50 && exp_q.size() > 0; k++) @(posedge clk);
        #3;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain left=%0d expected=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
